// File: rtl/soc_status_poll_master_if.sv
// Avalon-MM read-only bus between the status poller and a status slave.
interface soc_status_poll_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/soc_status_poll_master.sv
// Polls a status register over Avalon-MM until masked bits match,
// or until a cycle budget runs out.
module soc_status_poll_master #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int POLL_GAP     = 16,
    parameter int TIMEOUT_W    = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    poll_addr,
    input  logic [DATA_W-1:0]    poll_mask,
    input  logic [DATA_W-1:0]    poll_value,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    soc_status_poll_master_if.master avm,
    output logic                 busy,
    output logic                 done,
    output logic                 timed_out,
    output logic [DATA_W-1:0]    last_status,
    output logic [15:0]          poll_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP
    } state_t;

    localparam logic [1:0]  LAT      = 2'(READ_LATENCY);
    localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    mask_q, mask_d;
    logic [DATA_W-1:0]    value_q, value_d;
    logic [DATA_W-1:0]    status_q, status_d;
    logic [TIMEOUT_W-1:0] limit_q, limit_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [15:0]          gap_q, gap_d;
    logic [15:0]          count_q, count_d;
    logic [1:0]           lat_q, lat_d;
    logic                 pend_q, pend_d;
    logic                 issued_q, issued_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 to_q, to_d;

    logic expire;
    logic pend;
    logic abort_issue;
    logic rd;
    logic accept;
    logic sample;
    logic match;

    assign expire = busy_q && (limit_q != '0)
                    && (cnt_q == limit_q - 1'b1);
    assign pend   = pend_q | expire;

    // Once a read is on the bus it must complete, so only an
    // un-asserted ISSUE may be abandoned on timeout.
    assign abort_issue = (state_q == S_ISSUE) && pend && !issued_q;
    assign rd          = (state_q == S_ISSUE) && !abort_issue;
    assign accept      = rd && !avm.avm_waitrequest;
    assign sample      = (READ_LATENCY == 0) ? accept
                       : (state_q == S_WAIT) && (lat_q == LAT);
    assign match       = ((avm.avm_readdata ^ value_q) & mask_q) == '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            mask_q   <= '0;
            value_q  <= '0;
            status_q <= '0;
            limit_q  <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            count_q  <= '0;
            lat_q    <= '0;
            pend_q   <= 1'b0;
            issued_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            mask_q   <= mask_d;
            value_q  <= value_d;
            status_q <= status_d;
            limit_q  <= limit_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            count_q  <= count_d;
            lat_q    <= lat_d;
            pend_q   <= pend_d;
            issued_q <= issued_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            to_q     <= to_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        mask_d   = mask_q;
        value_d  = value_q;
        status_d = status_q;
        limit_d  = limit_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        count_d  = count_q;
        lat_d    = lat_q;
        pend_d   = pend;
        issued_d = issued_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        to_d     = 1'b0;

        if (busy_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = poll_addr;
                    mask_d   = poll_mask;
                    value_d  = poll_value;
                    limit_d  = timeout_limit;
                    cnt_d    = '0;
                    count_d  = '0;
                    pend_d   = 1'b0;
                    issued_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort_issue) begin
                    to_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (accept) begin
                    issued_d = 1'b0;
                    lat_d    = 2'd1;
                    state_d  = S_WAIT;
                end else begin
                    issued_d = 1'b1;
                end
            end
            S_WAIT: begin
                lat_d = lat_q + 2'd1;
            end
            S_GAP: begin
                if (pend) begin
                    to_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (gap_q == GAP_LAST) begin
                    state_d = S_ISSUE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A match on the final sample beats a pending timeout.
        if (sample) begin
            status_d = avm.avm_readdata;
            issued_d = 1'b0;
            if (count_q != '1) begin
                count_d = count_q + 16'd1;
            end
            if (match) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end else if (pend) begin
                to_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end else if (POLL_GAP == 0) begin
                state_d = S_ISSUE;
            end else begin
                gap_d   = '0;
                state_d = S_GAP;
            end
        end
    end

    always_comb begin
        avm.avm_read    = rd;
        avm.avm_address = rd ? addr_q : '0;
        busy            = busy_q;
        done            = done_q;
        timed_out       = to_q;
        last_status     = status_q;
        poll_count      = count_q;
    end

endmodule
